// File: rtl/button_events_pkg.sv
// Shared definitions for the button event block: register offsets and
// the bit position of the release half within EVENTS / IRQ_EN.
package button_events_pkg;

    localparam logic [1:0] REG_STATUS   = 2'd0;
    localparam logic [1:0] REG_EVENTS   = 2'd1;
    localparam logic [1:0] REG_IRQ_EN   = 2'd2;
    localparam logic [1:0] REG_DEBOUNCE = 2'd3;

    localparam int REL_SHIFT = 16;

endpackage

// File: rtl/btn_debounce.sv
// One button: two-flop synchroniser, stability counter, debounced state
// and a single-cycle commit strobe when the state flips.
module btn_debounce
    import button_events_pkg::*;
#(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             raw,
    input  logic [CNT_W-1:0] thr,
    output logic             state,
    output logic             commit
);

    logic             sync1;
    logic             sync2;
    logic             s;
    logic [CNT_W-1:0] cnt;

    // Pads are active-low; s is 1 while the button is held.
    assign s      = ~sync2;
    assign commit = (s != state) && (cnt >= thr - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            cnt   <= '0;
            state <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (s == state) begin
                cnt <= '0;
            end else if (commit) begin
                state <= s;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/button_events.sv
// Debounced buttons with sticky press/release events, a level interrupt
// and an iomem register window (STATUS, EVENTS, IRQ_EN, DEBOUNCE).
module button_events
    import button_events_pkg::*;
#(
    parameter int NBTN             = 2,
    parameter int DEBOUNCE_DEFAULT = 16000,
    parameter int CNT_W            = 20
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            iomem_valid,
    input  logic [3:0]      iomem_wstrb,
    input  logic [31:0]     iomem_addr,
    input  logic [31:0]     iomem_wdata,
    output logic [31:0]     iomem_rdata,
    output logic            iomem_ready,
    input  logic [NBTN-1:0] btn_raw,
    output logic [NBTN-1:0] btn_state,
    output logic            irq
);

    logic [NBTN-1:0]  commit;
    logic [NBTN-1:0]  press, rel, press_en, rel_en;
    logic [NBTN-1:0]  press_n, rel_n;
    logic [CNT_W-1:0] debounce, thr;
    logic [31:0]      wmask, wd, rd;
    logic [31:0]      st_w, ev_w, en_w, db_w, en_new, db_new;
    logic [1:0]       reg_sel;
    logic             acc, wr;
    logic             unused;

    // A programmed threshold of 0 is treated as 1.
    assign thr = (debounce == '0) ? CNT_W'(1) : debounce;

    for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
        btn_debounce #(.CNT_W(CNT_W)) u_db (
            .clk    (clk),
            .resetn (resetn),
            .raw    (btn_raw[gi]),
            .thr    (thr),
            .state  (btn_state[gi]),
            .commit (commit[gi])
        );
    end

    assign reg_sel = iomem_addr[3:2];
    assign acc     = iomem_valid && !iomem_ready;
    assign wr      = acc && (iomem_wstrb != 4'b0000);
    assign wmask   = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                      {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
    assign wd      = iomem_wdata & wmask;
    assign en_new  = (en_w & ~wmask) | wd;
    assign db_new  = (db_w & ~wmask) | wd;
    assign unused  = ^{iomem_addr[31:4], iomem_addr[1:0], wd, en_new, db_new};

    always_comb begin
        st_w = '0;
        ev_w = '0;
        en_w = '0;
        db_w = '0;
        st_w[NBTN-1:0]           = btn_state;
        ev_w[NBTN-1:0]           = press;
        ev_w[REL_SHIFT+:NBTN]    = rel;
        en_w[NBTN-1:0]           = press_en;
        en_w[REL_SHIFT+:NBTN]    = rel_en;
        db_w[CNT_W-1:0]          = debounce;
    end

    always_comb begin
        rd = '0;
        unique case (reg_sel)
            REG_STATUS:   rd = st_w;
            REG_EVENTS:   rd = ev_w;
            REG_IRQ_EN:   rd = en_w;
            REG_DEBOUNCE: rd = db_w;
        endcase
    end

    // Event set beats a simultaneous write-one-to-clear.
    always_comb begin
        press_n = press;
        rel_n   = rel;
        if (wr && reg_sel == REG_EVENTS) begin
            press_n = press & ~wd[NBTN-1:0];
            rel_n   = rel & ~wd[REL_SHIFT+:NBTN];
        end
        press_n = press_n | (commit & ~btn_state);
        rel_n   = rel_n | (commit & btn_state);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
            press       <= '0;
            rel         <= '0;
            press_en    <= '0;
            rel_en      <= '0;
            debounce    <= CNT_W'(DEBOUNCE_DEFAULT);
            irq         <= 1'b0;
        end else begin
            iomem_ready <= acc;
            iomem_rdata <= acc ? rd : '0;
            press       <= press_n;
            rel         <= rel_n;
            if (wr && reg_sel == REG_IRQ_EN) begin
                press_en <= en_new[NBTN-1:0];
                rel_en   <= en_new[REL_SHIFT+:NBTN];
            end
            if (wr && reg_sel == REG_DEBOUNCE)
                debounce <= db_new[CNT_W-1:0];
            irq <= |((press & press_en) | (rel & rel_en));
        end
    end

endmodule

// File: tb/tb_button_events.sv
// Scoreboard bench for button_events: reads queue their expected data,
// which is popped and compared when iomem_ready returns.
module tb_button_events;

    localparam int NBTN = 2;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            iomem_valid = 1'b0;
    logic [3:0]      iomem_wstrb = 4'h0;
    logic [31:0]     iomem_addr = '0;
    logic [31:0]     iomem_wdata = '0;
    logic [31:0]     iomem_rdata;
    logic            iomem_ready;
    logic [NBTN-1:0] btn_raw = '1;
    logic [NBTN-1:0] btn_state;
    logic            irq;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    button_events #(
        .NBTN             (NBTN),
        .DEBOUNCE_DEFAULT (16000),
        .CNT_W            (20)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .iomem_valid (iomem_valid),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .iomem_ready (iomem_ready),
        .btn_raw     (btn_raw),
        .btn_state   (btn_state),
        .irq         (irq)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus(input logic [1:0] r, input logic [3:0] ws,
                       input logic [31:0] wd, input logic [31:0] exp,
                       input string tag);
        bit got = 0;
        if (ws == 4'h0) begin
            exp_q.push_back(exp);
            tag_q.push_back(tag);
        end
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_wstrb = ws;
        iomem_addr  = {28'h0, r, 2'b00};
        iomem_wdata = wd;
        for (int k = 0; k < 8 && !got; k++) begin
            @(posedge clk);
            #1;
            if (iomem_ready) got = 1;
        end
        if (!got) chk({tag, "_ready"}, {31'h0, iomem_ready}, 32'h1);
        if (ws == 4'h0) begin
            if (got) chk(tag_q.pop_front(), iomem_rdata, exp_q.pop_front());
            else begin
                void'(tag_q.pop_front());
                void'(exp_q.pop_front());
            end
        end
        @(negedge clk);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
    endtask

    task automatic btn_change(input int i, input bit pressed,
                              input int lat, input string tag);
        @(negedge clk);
        btn_raw[i] = ~pressed;
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk);
            #1;
            if (k == lat - 1)
                chk({tag, "_early"}, {31'h0, btn_state[i]}, {31'h0, !pressed});
        end
        chk(tag, {31'h0, btn_state[i]}, {31'h0, pressed});
    endtask

    initial begin
        // Reset, with a request pending that must not be acknowledged.
        iomem_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'h0, iomem_ready}, 32'h0);
        chk("rst_rdata", iomem_rdata, 32'h0);
        chk("rst_state", {30'h0, btn_state}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        @(negedge clk);
        iomem_valid = 1'b0;
        resetn = 1'b1;

        bus(2'd0, 4'h0, 0, 32'h0, "rd_status0");
        bus(2'd1, 4'h0, 0, 32'h0, "rd_events0");
        bus(2'd2, 4'h0, 0, 32'h0, "rd_irqen0");
        bus(2'd3, 4'h0, 0, 32'd16000, "rd_deb0");
        chk("irq0", {31'h0, irq}, 32'h0);

        // Press with thr=4 -> visible 6 cycles later.
        bus(2'd3, 4'hf, 32'd4, 0, "wr_deb4");
        btn_change(0, 1, 6, "press0");
        bus(2'd1, 4'h0, 0, 32'h1, "ev_press0");
        bus(2'd0, 4'h0, 0, 32'h1, "st_press0");

        // A 3-cycle glitch on button 1 is filtered.
        bus(2'd1, 4'hf, 32'h1, 0, "clr_ev");
        @(negedge clk);
        btn_raw[1] = 1'b0;
        repeat (3) @(negedge clk);
        btn_raw[1] = 1'b1;
        repeat (10) @(negedge clk);
        chk("glitch_state", {30'h0, btn_state}, 32'h1);
        bus(2'd1, 4'h0, 0, 32'h0, "glitch_ev");

        // Release interrupt.
        bus(2'd2, 4'hf, 32'h0001_0000, 0, "wr_en_rel");
        btn_change(0, 0, 6, "rel0");
        chk("irq_rel_pre", {31'h0, irq}, 32'h0);
        @(posedge clk);
        #1;
        chk("irq_rel", {31'h0, irq}, 32'h1);
        bus(2'd1, 4'hf, 32'h0001_0001, 0, "clr_all");
        @(posedge clk);
        #1;
        chk("irq_clr", {31'h0, irq}, 32'h0);
        btn_change(0, 1, 6, "press0b");
        repeat (2) @(posedge clk);
        #1;
        chk("irq_press_masked", {31'h0, irq}, 32'h0);
        btn_change(0, 0, 6, "rel0b");
        chk("irq_rel_pre_b", {31'h0, irq}, 32'h0);
        @(posedge clk);
        #1;
        chk("irq_rel_b", {31'h0, irq}, 32'h1);
        bus(2'd1, 4'hf, 32'h0001_0000, 0, "clr_rel");
        @(posedge clk);
        #1;
        chk("irq_clr_b", {31'h0, irq}, 32'h0);
        bus(2'd1, 4'h0, 0, 32'h1, "ev_press_kept");
        bus(2'd1, 4'hf, 32'h1, 0, "clr_press");
        bus(2'd2, 4'hf, 32'h0, 0, "wr_en0");

        // DEBOUNCE=0 acts as a threshold of 1 -> latency 3.
        bus(2'd3, 4'hf, 32'h0, 0, "wr_deb0");
        bus(2'd3, 4'h0, 0, 32'h0, "rd_deb_zero");
        btn_change(1, 1, 3, "thr1_press");
        btn_change(1, 0, 3, "thr1_rel");
        bus(2'd1, 4'h0, 0, 32'h0002_0002, "ev_thr1");
        bus(2'd1, 4'hf, 32'hffff_ffff, 0, "clr_thr1");

        // Button held through reset; default threshold applies.
        @(negedge clk);
        resetn = 1'b0;
        btn_raw[0] = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        for (int k = 1; k <= 16002; k++) begin
            @(posedge clk);
            #1;
            if (k == 16001)
                chk("held_early", {31'h0, btn_state[0]}, 32'h0);
        end
        chk("held_state", {31'h0, btn_state[0]}, 32'h1);
        bus(2'd1, 4'h0, 0, 32'h1, "held_ev");

        // valid held continuously: two accesses, ready 1,0,1,0.
        exp_q.push_back(32'h1);
        tag_q.push_back("b2b_rd0");
        exp_q.push_back(32'h1);
        tag_q.push_back("b2b_rd1");
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_wstrb = 4'h0;
        iomem_addr  = 32'h0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("b2b_ready%0d", k), {31'h0, iomem_ready},
                {31'h0, (k % 2 == 0)});
            if (iomem_ready && exp_q.size() > 0)
                chk(tag_q.pop_front(), iomem_rdata, exp_q.pop_front());
        end
        @(negedge clk);
        iomem_valid = 1'b0;

        // W1C of REL lands in the same cycle REL is set: set wins.
        bus(2'd3, 4'hf, 32'd4, 0, "wr_deb4b");
        bus(2'd1, 4'hf, 32'h1, 0, "clr_held");
        @(negedge clk);
        btn_raw[0] = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_wstrb = 4'hf;
        iomem_addr  = 32'h4;
        iomem_wdata = 32'h0001_0000;
        @(posedge clk);
        #1;
        chk("race_ready", {31'h0, iomem_ready}, 32'h1);
        chk("race_state", {31'h0, btn_state[0]}, 32'h0);
        @(negedge clk);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        bus(2'd1, 4'h0, 0, 32'h0001_0000, "race_ev");

        // Byte strobes and unimplemented bits.
        bus(2'd3, 4'b0010, 32'hffff_ffff, 0, "wr_deb_b1");
        bus(2'd3, 4'h0, 0, 32'h0000_ff04, "rd_deb_b1");
        bus(2'd3, 4'hf, 32'hffff_ffff, 0, "wr_deb_all");
        bus(2'd3, 4'h0, 0, 32'h000f_ffff, "rd_deb_all");
        bus(2'd2, 4'hf, 32'hffff_ffff, 0, "wr_en_all");
        bus(2'd2, 4'h0, 0, 32'h0003_0003, "rd_en_all");
        bus(2'd2, 4'b0100, 32'h0, 0, "wr_en_b2");
        bus(2'd2, 4'h0, 0, 32'h0000_0003, "rd_en_b2");
        bus(2'd0, 4'hf, 32'hffff_ffff, 0, "wr_status");
        bus(2'd0, 4'h0, 0, 32'h0, "rd_status_ro");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/button_events.md
Name: button_events

Overview:
- Memory-mapped input stage between the board button pads and software on the PicoSOC iomem bus; sits directly upstream of the gpio block's button read path.
- Synchronises and debounces each raw active-low button and tracks the debounced state.
- Latches sticky press/release events and raises a level interrupt for enabled events.
- Exports the debounced state as `btn_state` so the gpio block reads clean levels instead of raw pads.

Parameters:
- NBTN, 2, number of buttons (1..16).
- DEBOUNCE_DEFAULT, 16000, reset value of the DEBOUNCE register in clk cycles (1 ms at 16 MHz).
- CNT_W, 20, width of each per-button debounce counter and of the DEBOUNCE register field.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- iomem_valid  in  1  bus request, held until iomem_ready
- iomem_wstrb  in  4  byte write strobes; 0 = read
- iomem_addr  in  32  byte address; only [3:2] decoded
- iomem_wdata  in  32  write data
- iomem_rdata  out  32  read data, valid when iomem_ready=1
- iomem_ready  out  1  one-cycle acknowledge
- btn_raw  in  NBTN  raw pad inputs, active-low, pulled up
- btn_state  out  NBTN  debounced state, 1 = pressed
- irq  out  1  level interrupt, registered

Behaviour:
- Reset:
  - resetn is synchronous, active-low; clock is clk.
  - While resetn=0: iomem_ready=0, iomem_rdata=0, btn_state=0, EVENTS=0, IRQ_EN=0, irq=0, all counters=0, DEBOUNCE=DEBOUNCE_DEFAULT.
  - Synchroniser flops reset to 1 (released).
- Input path:
  - Two-flop synchroniser per bit, then invert: s = ~sync2.
- Debounce, per button i:
  - If s[i]==btn_state[i], the counter clears to 0.
  - Otherwise the counter increments. When counter >= thr-1, where thr = max(DEBOUNCE,1):
    - btn_state[i] <= s[i]
    - counter <= 0
    - a one-cycle commit occurs.
  - Latency: an input change held stable is reflected on btn_state exactly thr+2 cycles later (2 sync + thr count).
  - A glitch shorter than thr cycles produces no change.
  - DEBOUNCE rewritten mid-count: the compare uses the new value from the next cycle. If the counter is already >= thr-1, the commit happens next cycle; no wrap.
- Events:
  - A commit to 1 sets PRESS[i]; a commit to 0 sets REL[i].
  - Bits are sticky until written 1 to clear.
  - Set and W1C on the same bit in the same cycle: set wins.
- irq:
  - Registered |(EVENTS & IRQ_EN); asserts 1 cycle after the event bit sets.
  - Deasserts 1 cycle after the clear or disable.
- Register map (addr[3:2]):
  - 0 STATUS, RO: [NBTN-1:0] = btn_state; writes ignored.
  - 1 EVENTS, R/W1C: [NBTN-1:0] = PRESS; [16+NBTN-1:16] = REL.
  - 2 IRQ_EN, RW: same bit layout as EVENTS.
  - 3 DEBOUNCE, RW: [CNT_W-1:0]; write of 0 behaves as 1.
  - Unimplemented bits read 0.
  - Byte strobes apply per byte for writes.
- Handshake:
  - iomem_ready <= 0 every cycle, except when iomem_valid && !iomem_ready: then iomem_ready <= 1 and the access is performed.
  - Exactly one access per request; ready is high for one cycle.
  - Read of EVENTS returns the pre-clear value. A read and a concurrent event set the same cycle: rdata shows the old value; the bit is set afterwards.
- Reset asserted mid-transaction: ready drops and the access is lost; the master retries.

Decomposition:
- Shared package `button_events_pkg`:
  - register offsets REG_STATUS=0, REG_EVENTS=1, REG_IRQ_EN=2, REG_DEBOUNCE=3
  - REL_SHIFT=16
- One natural sub-module, `btn_debounce`:
  - one button's synchroniser, counter, stable bit and commit pulse
  - instantiated NBTN times
  - thr supplied as an input

Test Plan:
- Reset, then read all 4 registers -> STATUS=0, EVENTS=0, IRQ_EN=0, DEBOUNCE=16000; irq=0.
- DEBOUNCE=4; drive btn_raw[0] low and hold -> btn_state[0]=1 exactly 6 cycles later; EVENTS=0x00000001.
- DEBOUNCE=4; pulse btn_raw[1] low for 3 cycles -> btn_state unchanged; EVENTS=0.
- IRQ_EN=0x00010000; press then release button 0 -> irq rises 1 cycle after REL[0] sets. Write EVENTS=0x00010000 -> irq=0; PRESS[0] remains set (EVENTS=0x1).
- Hold button pressed through reset -> after release of reset plus thr+2 cycles, btn_state=1 and PRESS set.
- Back-to-back reads with iomem_valid held continuously -> ready pulses 1, 0, 1 (one per transaction). W1C in the same cycle as a commit -> bit stays 1.
